// File: rtl/pwm_decoder.sv
// Recovers duty and period from an asynchronous PWM line: synchronizes, detects edges,
// times them with a saturating counter and reports one measurement per complete period.
module pwm_decoder #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        PWM_in,
  output logic [7:0]  x_out,
  output logic [15:0] high_out,
  output logic [15:0] period_out,
  output logic        valid_out,
  output logic        stuck_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_hist;
  logic        r_rise;
  logic        r_fall;
  logic [15:0] r_cnt;
  logic [15:0] r_high_cap;
  state_t      r_state;

  logic        w_edge;
  logic        w_timeout;
  logic [16:0] w_period_sum;
  logic [15:0] w_period;
  logic [7:0]  w_x;

  assign w_edge    = r_rise | r_fall;
  assign w_timeout = (r_cnt == TIMEOUT_C) && !w_edge;

  // cnt restarts at the fall, so the rising-to-rising period is high time plus low time.
  assign w_period_sum = {1'b0, r_high_cap} + {1'b0, r_cnt};
  assign w_period     = w_period_sum[16] ? 16'hFFFF : w_period_sum[15:0];
  assign w_x          = (|r_high_cap[15:8]) ? 8'hFF : r_high_cap[7:0];

  // NOTE: every sequential block uses non-blocking assignments so that all flops sample
  // the pre-edge values of their neighbours, exactly like the hardware they describe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= PWM_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_rise  <= r_sync2 & ~r_hist;
      r_fall  <= ~r_sync2 & r_hist;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= 16'd0;
    end else if (w_edge) begin
      r_cnt <= 16'd1;
    end else if (r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_high_cap <= 16'd0;
      x_out      <= 8'd0;
      high_out   <= 16'd0;
      period_out <= 16'd0;
      valid_out  <= 1'b0;
      stuck_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_rise) r_state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (r_fall) begin
            r_state    <= ST_LOW;
            r_high_cap <= r_cnt;
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            stuck_out <= 1'b1;
            x_out     <= 8'hFF;
          end
        end
        ST_LOW: begin
          if (r_rise) begin
            r_state    <= ST_HIGH;
            high_out   <= r_high_cap;
            period_out <= w_period;
            x_out      <= w_x;
            valid_out  <= 1'b1;
            stuck_out  <= 1'b0;
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            stuck_out <= 1'b1;
            x_out     <= 8'h00;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: the driver plays PWM segments and a timeline model
// predicts each measurement / stuck event; a monitor pops and compares them.
module tb_pwm_decoder;

  localparam int TIMEOUT = 1024;
  localparam int LAT     = 4;

  logic        clk_in;
  logic        rst_n_in;
  logic        PWM_in;
  logic [7:0]  x_out;
  logic [15:0] high_out;
  logic [15:0] period_out;
  logic        valid_out;
  logic        stuck_out;

  pwm_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .PWM_in    (PWM_in),
    .x_out     (x_out),
    .high_out  (high_out),
    .period_out(period_out),
    .valid_out (valid_out),
    .stuck_out (stuck_out)
  );

  typedef struct {
    bit is_stuck;
    int cyc;
    int x;
    int h;
    int p;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Model state: 0 idle, 1 high, 2 low, tracked on the input timeline.
  int  m_state;
  bit  m_lvl;
  int  m_rise_t;
  int  m_h;
  int  last_h;
  int  last_p;
  bit  prev_stuck;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_state  = 0;
    m_lvl    = 1'b0;
    m_rise_t = 0;
    m_h      = 0;
    last_h   = 0;
    last_p   = 0;
  endfunction

  // Level lvl starts at input cycle k and lasts dur cycles.
  function automatic void model_seg(input bit lvl, input int k, input int dur);
    ev_t e;
    if (lvl != m_lvl) begin
      if (lvl) begin
        if (m_state == 2) begin
          e.is_stuck = 1'b0;
          e.cyc = k + LAT;
          e.h   = m_h;
          e.p   = k - m_rise_t;
          e.x   = (m_h > 255) ? 255 : m_h;
          last_h = e.h;
          last_p = e.p;
          q.push_back(e);
        end
        m_state  = 1;
        m_rise_t = k;
      end else if (m_state == 1) begin
        m_h     = k - m_rise_t;
        m_state = 2;
      end
      m_lvl = lvl;
    end
    if (dur > TIMEOUT && m_state != 0) begin
      e.is_stuck = 1'b1;
      e.cyc = k + TIMEOUT + LAT;
      e.h   = last_h;
      e.p   = last_p;
      e.x   = lvl ? 255 : 0;
      q.push_back(e);
      m_state = 0;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 dur cycles later.
  task automatic seg(input bit lvl, input int dur);
    PWM_in = lvl;
    model_seg(lvl, cyc, dur);
    repeat (dur) @(posedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    ev_t e;
    if (!rst_n_in) begin
      prev_stuck = 1'b0;
    end else begin
      if (valid_out) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("valid_kind", int'(e.is_stuck), 0);
          check("valid_cycle", cyc, e.cyc);
          check("valid_x", int'(x_out), e.x);
          check("valid_high", int'(high_out), e.h);
          check("valid_period", int'(period_out), e.p);
          check("valid_stuck_clear", int'(stuck_out), 0);
        end
      end
      if (stuck_out && !prev_stuck) begin
        if (q.size() == 0) begin
          check("unexpected_stuck", 1, 0);
        end else begin
          e = q.pop_front();
          check("stuck_kind", int'(e.is_stuck), 1);
          check("stuck_cycle", cyc, e.cyc);
          check("stuck_x", int'(x_out), e.x);
          check("stuck_high_hold", int'(high_out), e.h);
          check("stuck_period_hold", int'(period_out), e.p);
        end
      end
      prev_stuck = stuck_out;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(x_out), 0);
    check({tag, "_high"}, int'(high_out), 0);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_valid"}, int'(valid_out), 0);
    check({tag, "_stuck"}, int'(stuck_out), 0);
  endtask

  initial begin
    int h;
    int l;
    rst_n_in = 1'b0;
    PWM_in   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    rst_n_in = 1'b1;

    for (int i = 0; i < 4; i++) begin
      seg(1'b1, 128);
      seg(1'b0, 128);
    end
    seg(1'b1, 255); seg(1'b0, 1);
    seg(1'b1, 2);   seg(1'b0, 254);
    seg(1'b1, 300); seg(1'b0, 100);
    seg(1'b1, TIMEOUT); seg(1'b0, TIMEOUT);
    seg(1'b1, 128); seg(1'b0, 1500);
    seg(1'b1, 100); seg(1'b0, 100);
    seg(1'b1, 2000);
    seg(1'b0, 50);  seg(1'b1, 60); seg(1'b0, 70);
    seg(1'b1, 50);

    // Asynchronous reset in the middle of a high phase, released with the line still high.
    #3;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    model_reset();
    seg(1'b1, 80);
    seg(1'b0, 120);

    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(2, 400);
      l = $urandom_range(2, 400);
      if (i == 0) h = 255;
      if (i == 1) h = 256;
      if (i % 8 == 7) l = $urandom_range(TIMEOUT + 1, TIMEOUT + 100);
      seg(1'b1, h);
      seg(1'b0, l);
    end
    seg(1'b1, 10);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk_in);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
